// File: rtl/inputconditioner_multi.sv
//------------------------------------------------------------------------------
// Module  : inputconditioner_multi
// Brief   : N-channel synchroniser + debouncer with level and edge strobes.
//           Optional per-channel glitch counters when INCOND_GLITCHCOUNT_EN is defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inputconditioner_multi #(
   parameter int                  CHANNELS    = 4,
   parameter int                  SYNC_STAGES = 2,
   parameter int                  WAIT_CYCLES = 3,
   parameter logic [CHANNELS-1:0] RESET_VALUE = {CHANNELS{1'b0}}
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] noisysignal,
   output logic [CHANNELS-1:0] conditioned,
   output logic [CHANNELS-1:0] positiveedge,
   output logic [CHANNELS-1:0] negativeedge,
   output logic [CHANNELS-1:0] busy
`ifdef INCOND_GLITCHCOUNT_EN
   ,
   output logic [CHANNELS*8-1:0] glitchcount
`endif
);

   localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0] c_last = CNT_W'(WAIT_CYCLES - 1);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CNT_W-1:0]       r_cnt;
      logic                   r_cond;
      logic                   r_pos;
      logic                   r_neg;
      logic                   w_synced;

      assign w_synced = r_sync[SYNC_STAGES-1];

      always_ff @(posedge clk) begin
         if (reset) begin
            r_sync <= {SYNC_STAGES{RESET_VALUE[i]}};
         end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], noisysignal[i]};
         end
      end

      // A change is accepted only after WAIT_CYCLES consecutive differing samples.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_cond <= RESET_VALUE[i];
            r_cnt  <= '0;
            r_pos  <= 1'b0;
            r_neg  <= 1'b0;
         end else begin
            r_pos <= 1'b0;
            r_neg <= 1'b0;
            if (w_synced == r_cond) begin
               r_cnt <= '0;
            end else if (r_cnt == c_last) begin
               r_cond <= w_synced;
               r_cnt  <= '0;
               r_pos  <= w_synced;
               r_neg  <= ~w_synced;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end

      assign conditioned[i]  = r_cond;
      assign positiveedge[i] = r_pos;
      assign negativeedge[i] = r_neg;
      assign busy[i]         = (r_cnt != '0);

`ifdef INCOND_GLITCHCOUNT_EN
      logic [7:0] r_gcnt;

      // Counts aborted pending changes, saturating at 255.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_gcnt <= '0;
         end else if ((r_cnt != '0) && (w_synced == r_cond) && (r_gcnt != 8'hFF)) begin
            r_gcnt <= r_gcnt + 8'd1;
         end
      end

      assign glitchcount[8*i +: 8] = r_gcnt;
`endif
   end : g_chan

endmodule

`default_nettype wire
